// File: rtl/ioctl_word_loader.sv
// ioctl download bridge: packs ioctl bytes into DATA_W words with byte enables,
// queues them in a small FIFO and drains them to a req/ack memory port with back-pressure.
module ioctl_word_loader #(
  parameter int         DATA_W     = 16,
  parameter int         ADDR_W     = 24,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] INDEX      = 8'd0,
  parameter int         BASE_ADDR  = 0
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic [7:0]            ioctl_index,
  output logic                  ioctl_wait,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic [24:0]           byte_count
);

  localparam int BPW = DATA_W / 8;
  localparam int SH  = $clog2(BPW);
  localparam int LW  = (BPW > 1) ? SH : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_r, state_nx_s;
  logic              dl_prev_r;
  logic              rise_s, fall_s;

  logic              pack_valid_r, pack_done_r;
  logic [ADDR_W-1:0] pack_addr_r;
  logic [DATA_W-1:0] pack_data_r;
  logic [BPW-1:0]    pack_be_r;
  logic              pack_valid_nx_s, pack_done_nx_s;
  logic [ADDR_W-1:0] pack_addr_nx_s;
  logic [DATA_W-1:0] pack_data_nx_s;
  logic [BPW-1:0]    pack_be_nx_s;

  logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [BPW-1:0]    fifo_be_r   [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r, count_s, count_nx_s;
  logic              fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic [ADDR_W-1:0] push_addr_s;
  logic [DATA_W-1:0] push_data_s;
  logic [BPW-1:0]    push_be_s;

  logic [ADDR_W-1:0] byte_word_s;
  logic [LW-1:0]     lane_s;
  logic              lane_last_s, wr_ok_s, same_word_s;
  logic [BPW-1:0]    byte_be_s, merge_be_s;
  logic [DATA_W-1:0] merge_data_s;

  logic              mem_req_r, busy_r, done_r, wait_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_data_r;
  logic [BPW-1:0]    mem_be_r;
  logic [24:0]       byte_count_r;

  generate
    if (BPW > 1) begin : g_lane
      assign lane_s = ioctl_addr[LW-1:0];
    end else begin : g_lane_single
      assign lane_s = 1'b0;
    end
  endgenerate

  assign byte_word_s  = ADDR_W'(ioctl_addr >> SH);
  assign lane_last_s  = (lane_s == LW'(BPW - 1));
  assign byte_be_s    = BPW'(1'b1) << lane_s;
  assign rise_s       = ioctl_download & ~dl_prev_r;
  assign fall_s       = ~ioctl_download & dl_prev_r;
  assign count_s      = wr_ptr_r - rd_ptr_r;
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                        (wr_ptr_r[PW-2:0] == rd_ptr_r[PW-2:0]);
  assign wr_ok_s      = (state_r == LOAD) && ioctl_wr && !fifo_full_s;
  // A completed word never absorbs further bytes, even to the same address.
  assign same_word_s  = pack_valid_r && !pack_done_r && (pack_addr_r == byte_word_s);
  assign pop_s        = !fifo_empty_s && (!mem_req_r || mem_ack);
  assign count_nx_s   = count_s + PW'(push_s) - PW'(pop_s);

  // Merge the incoming byte into either the pending word or a fresh zeroed word.
  always_comb begin
    merge_be_s   = byte_be_s;
    merge_data_s = '0;
    if (same_word_s) begin
      merge_be_s = pack_be_r | byte_be_s;
    end else begin
      merge_be_s = byte_be_s;
    end
    for (int k = 0; k < BPW; k++) begin
      if (byte_be_s[k]) begin
        merge_data_s[8*k +: 8] = ioctl_dout;
      end else if (same_word_s) begin
        merge_data_s[8*k +: 8] = pack_data_r[8*k +: 8];
      end else begin
        merge_data_s[8*k +: 8] = 8'h00;
      end
    end
  end

  // Pack register update and FIFO push selection (at most one push per cycle).
  always_comb begin
    push_s          = 1'b0;
    push_addr_s     = pack_addr_r;
    push_data_s     = pack_data_r;
    push_be_s       = pack_be_r;
    pack_valid_nx_s = pack_valid_r;
    pack_done_nx_s  = pack_done_r;
    pack_addr_nx_s  = pack_addr_r;
    pack_data_nx_s  = pack_data_r;
    pack_be_nx_s    = pack_be_r;
    if (wr_ok_s) begin
      if (pack_valid_r && !same_word_s) begin
        // Pending word leaves first; a new word completed here goes out next cycle.
        push_s          = 1'b1;
        pack_valid_nx_s = 1'b1;
        pack_done_nx_s  = lane_last_s;
        pack_addr_nx_s  = byte_word_s;
        pack_data_nx_s  = merge_data_s;
        pack_be_nx_s    = merge_be_s;
      end else if (lane_last_s) begin
        push_s          = 1'b1;
        push_addr_s     = byte_word_s;
        push_data_s     = merge_data_s;
        push_be_s       = merge_be_s;
        pack_valid_nx_s = 1'b0;
        pack_done_nx_s  = 1'b0;
        pack_data_nx_s  = '0;
        pack_be_nx_s    = '0;
      end else begin
        pack_valid_nx_s = 1'b1;
        pack_done_nx_s  = 1'b0;
        pack_addr_nx_s  = byte_word_s;
        pack_data_nx_s  = merge_data_s;
        pack_be_nx_s    = merge_be_s;
      end
    end else if (pack_valid_r && (pack_done_r || state_r == FLUSH) && !fifo_full_s) begin
      push_s          = 1'b1;
      pack_valid_nx_s = 1'b0;
      pack_done_nx_s  = 1'b0;
      pack_data_nx_s  = '0;
      pack_be_nx_s    = '0;
    end else begin
      push_s = 1'b0;
    end
  end

  // Download state machine next-state.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s && (ioctl_index == INDEX)) begin
          state_nx_s = LOAD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        if (fall_s) begin
          state_nx_s = FLUSH;
        end else begin
          state_nx_s = LOAD;
        end
      end
      FLUSH: begin
        if (!pack_valid_r && fifo_empty_s && !mem_req_r) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = FLUSH;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Control state, pack register, pointers and registered status outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      dl_prev_r    <= 1'b0;
      pack_valid_r <= 1'b0;
      pack_done_r  <= 1'b0;
      pack_addr_r  <= '0;
      pack_data_r  <= '0;
      pack_be_r    <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      wait_r       <= 1'b0;
      byte_count_r <= 25'd0;
    end else begin
      state_r      <= state_nx_s;
      dl_prev_r    <= ioctl_download;
      pack_valid_r <= pack_valid_nx_s;
      pack_done_r  <= pack_done_nx_s;
      pack_addr_r  <= pack_addr_nx_s;
      pack_data_r  <= pack_data_nx_s;
      pack_be_r    <= pack_be_nx_s;
      wr_ptr_r     <= wr_ptr_r + PW'(push_s);
      rd_ptr_r     <= rd_ptr_r + PW'(pop_s);
      busy_r       <= (state_nx_s != IDLE);
      done_r       <= (state_nx_s == DONE);
      // Threshold one below full leaves a slot for a write already in flight.
      wait_r       <= (count_nx_s >= PW'(FIFO_DEPTH - 1)) ||
                      (state_nx_s == FLUSH) || (state_nx_s == DONE);
      if ((state_r == IDLE) && (state_nx_s == LOAD)) begin
        byte_count_r <= 25'd0;
      end else if (wr_ok_s && (byte_count_r != 25'h1FFFFFF)) begin
        byte_count_r <= byte_count_r + 25'd1;
      end else begin
        byte_count_r <= byte_count_r;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_sys) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r[AW-1:0]] <= push_addr_s;
      fifo_data_r[wr_ptr_r[AW-1:0]] <= push_data_s;
      fifo_be_r[wr_ptr_r[AW-1:0]]   <= push_be_s;
    end
  end

  // Memory port output stage; refills in the ack cycle for one word per clock.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_req_r  <= 1'b0;
      mem_addr_r <= '0;
      mem_data_r <= '0;
      mem_be_r   <= '0;
    end else if (pop_s) begin
      mem_req_r  <= 1'b1;
      mem_addr_r <= fifo_addr_r[rd_ptr_r[AW-1:0]] + ADDR_W'(BASE_ADDR);
      mem_data_r <= fifo_data_r[rd_ptr_r[AW-1:0]];
      mem_be_r   <= fifo_be_r[rd_ptr_r[AW-1:0]];
    end else if (mem_req_r && mem_ack) begin
      mem_req_r  <= 1'b0;
    end else begin
      mem_req_r  <= mem_req_r;
    end
  end

  assign ioctl_wait = wait_r;
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign mem_data   = mem_data_r;
  assign mem_be     = mem_be_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign byte_count = byte_count_r;

endmodule

// File: tb/tb_ioctl_word_loader.sv
// Bench for ioctl_word_loader (16-bit words, BASE_ADDR=3): directed and random downloads
// checked against a byte-grouping reference model and a memory-port monitor.
module tb_ioctl_word_loader;

  localparam int BASE = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wait;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        done;
  logic [24:0] byte_count;

  always #5 clk_sys = ~clk_sys;

  ioctl_word_loader #(
    .DATA_W(16), .ADDR_W(24), .FIFO_DEPTH(4), .INDEX(8'd0), .BASE_ADDR(BASE)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be), .mem_ack(mem_ack),
    .busy(busy), .done(done), .byte_count(byte_count)
  );

  typedef struct packed {
    logic [23:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } word_t;

  int          tests = 0;
  int          fails = 0;
  word_t       exp_q[$];
  int unsigned byte_a[$];
  logic [7:0]  byte_v[$];
  int          ack_mode = 0;   // 0: always ack, 1: random ack, 2: never ack
  int          words_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: consecutive bytes of one word address form a word; a word closes on its
  // top lane, on a change of word address, or at the end of the download.
  task automatic model();
    bit          gv = 1'b0;
    int unsigned ga = 0;
    logic [15:0] gd = 16'h0000;
    logic [1:0]  gb = 2'b00;
    for (int i = 0; i < byte_a.size(); i++) begin
      int unsigned wa;
      int          ln;
      wa = byte_a[i] / 2;
      ln = byte_a[i] % 2;
      if (gv && wa != ga) begin
        exp_q.push_back({24'(BASE + ga), gd, gb});
        gv = 1'b0;
      end
      if (!gv) begin
        gv = 1'b1; ga = wa; gd = 16'h0000; gb = 2'b00;
      end
      gd[8*ln +: 8] = byte_v[i];
      gb[ln] = 1'b1;
      if (ln == 1) begin
        exp_q.push_back({24'(BASE + ga), gd, gb});
        gv = 1'b0;
      end
    end
    if (gv) exp_q.push_back({24'(BASE + ga), gd, gb});
  endtask

  task automatic gen(input int n, input int unsigned start, input bit jumps);
    int unsigned a = start;
    byte_a.delete();
    byte_v.delete();
    for (int i = 0; i < n; i++) begin
      byte_a.push_back(a);
      byte_v.push_back(8'($urandom));
      if (jumps && $urandom_range(0, 5) == 0) a += $urandom_range(2, 9);
      else a += 1;
    end
  endtask

  task automatic add_byte(input int unsigned a, input logic [7:0] v);
    byte_a.push_back(a);
    byte_v.push_back(v);
  endtask

  // Full download honouring ioctl_wait; optional stall scenario releases ack after 20 stalled cycles.
  task automatic drive(input string tag, input bit stall_test);
    int guard;
    int ws0 = words_seen;
    model();
    ioctl_index = 8'd0;
    @(negedge clk_sys) ioctl_download = 1'b1;
    @(negedge clk_sys);
    check({tag, "_busy"}, busy, 1'b1);
    for (int i = 0; i < byte_a.size(); i++) begin
      guard = 0;
      while (ioctl_wait) begin
        ioctl_wr = 1'b0;
        if (stall_test && ack_mode == 2 && guard == 20) begin
          check({tag, "_stall_req"}, mem_req, 1'b1);
          check({tag, "_stall_noack"}, words_seen - ws0, 0);
          check({tag, "_stall_3words"}, byte_count >= 25'd6, 1'b1);
          check({tag, "_stall_held"}, byte_count < 25'(byte_a.size()), 1'b1);
          ack_mode = 0;
        end
        if (guard > 2000) begin
          check({tag, "_wait_timeout"}, ioctl_wait, 1'b0);
          break;
        end
        @(negedge clk_sys);
        guard++;
      end
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(byte_a[i]);
      ioctl_dout = byte_v[i];
      @(negedge clk_sys);
      if ($urandom_range(0, 3) == 0) begin
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
      end
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    guard = 0;
    while (!done && guard < 3000) begin
      @(negedge clk_sys);
      guard++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_byte_count"}, byte_count, 25'(byte_a.size()));
    check({tag, "_all_words"}, exp_q.size(), 0);
    @(negedge clk_sys);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // Memory-port monitor: drives mem_ack, scores accepted words, checks request stability.
  initial begin
    logic  prev_pend = 1'b0;
    word_t prev_w = '0;
    logic  ack_n;
    word_t cur, e;
    forever begin
      @(negedge clk_sys);
      cur = {mem_addr, mem_data, mem_be};
      if (!reset_n) begin
        prev_pend = 1'b0;
        mem_ack = 1'b0;
      end else begin
        if (prev_pend) begin
          check("req_held", mem_req, 1'b1);
          check("req_stable", cur, prev_w);
        end
        case (ack_mode)
          0:       ack_n = 1'b1;
          1:       ack_n = 1'($urandom_range(0, 1));
          default: ack_n = 1'b0;
        endcase
        mem_ack = ack_n;
        if (mem_req && ack_n) begin
          words_seen++;
          tests++;
          assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_word observed=%0h expected=none", cur);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("word", cur, e);
          end
          prev_pend = 1'b0;
        end else begin
          prev_pend = mem_req;
        end
        prev_w = cur;
      end
    end
  end

  initial begin
    int bc0, ws0;
    repeat (3) @(negedge clk_sys);
    check("rst_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_count", byte_count, 25'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Sequential full words, always-ack
    ack_mode = 0;
    byte_a.delete(); byte_v.delete();
    add_byte(0, 8'h11); add_byte(1, 8'h22); add_byte(2, 8'h33); add_byte(3, 8'h44);
    drive("t1", 1'b0);

    // Odd byte count leaves a partial word for the flush
    byte_a.delete(); byte_v.delete();
    add_byte(0, 8'hAA); add_byte(1, 8'hBB); add_byte(2, 8'hCC);
    drive("t2", 1'b0);

    // Address jump splits words
    byte_a.delete(); byte_v.delete();
    add_byte(4, 8'h5A); add_byte(9, 8'hC3);
    drive("t3", 1'b0);

    // Back-pressure with ack held off
    ack_mode = 2;
    gen(64, 0, 1'b0);
    drive("t4", 1'b1);

    // Random addresses, jumps and acks
    ack_mode = 1;
    for (int r = 0; r < 6; r++) begin
      gen($urandom_range(1, 40), $urandom_range(0, 300), 1'b1);
      drive("rnd", 1'b0);
    end

    // Wrong index is ignored
    ack_mode = 0;
    bc0 = int'(byte_count);
    ws0 = words_seen;
    ioctl_index = 8'd5;
    @(negedge clk_sys) ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i + 8'h70);
      @(negedge clk_sys);
      check("t5_busy", busy, 1'b0);
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("t5_noreq", words_seen - ws0, 0);
    check("t5_count", byte_count, 25'(bc0));
    check("t5_idle", busy, 1'b0);
    ioctl_index = 8'd0;

    // Reset in the middle of a download with a request outstanding
    ack_mode = 2;
    byte_a.delete(); byte_v.delete();
    add_byte(0, 8'h01); add_byte(1, 8'h02); add_byte(2, 8'h03); add_byte(3, 8'h04);
    model();
    @(negedge clk_sys) ioctl_download = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(byte_a[i]);
      ioctl_dout = byte_v[i];
      @(negedge clk_sys);
    end
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("t6_req_before", mem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_req_low", mem_req, 1'b0);
    check("t6_busy_low", busy, 1'b0);
    check("t6_wait_low", ioctl_wait, 1'b0);
    exp_q.delete();
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys) reset_n = 1'b1;
    ack_mode = 0;
    gen(6, 0, 1'b0);
    drive("t6_clean", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
